// File: rtl/regfile_mp.sv
// Multi-port register-pair file: two read ports, byte write, full-register step and copy,
// and a handshaked snapshot dump stream for the debug path.
module regfile_mp #(
  parameter int NUM_REGS = 5,
  parameter int IDX_W    = 3,
  parameter int BYTE_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W+1:0]      rf_rn_out_a,
  input  logic [IDX_W+1:0]      rf_rn_out_b,
  output logic [2*BYTE_W-1:0]   rf_data_out_a,
  output logic [2*BYTE_W-1:0]   rf_data_out_b,
  input  logic                  rf_we,
  input  logic [IDX_W+1:0]      rf_rn_in,
  input  logic [BYTE_W-1:0]     rf_data_in,
  input  logic                  rf_step_en,
  input  logic [IDX_W-1:0]      rf_step_idx,
  input  logic                  rf_step_dec,
  input  logic                  rf_copy_en,
  input  logic [IDX_W-1:0]      rf_copy_src,
  input  logic [IDX_W-1:0]      rf_copy_dst,
  output logic                  rf_conflict,
  input  logic                  dump_req,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [IDX_W-1:0]      dump_idx,
  output logic [2*BYTE_W-1:0]   dump_data
);
  localparam int DW = 2 * BYTE_W;
  localparam logic [IDX_W:0]   NUM_L    = (IDX_W + 1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {IDLE, DUMP} state_e;

  logic [DW-1:0]    regs_q   [NUM_REGS];
  logic [DW-1:0]    regs_d   [NUM_REGS];
  logic [DW-1:0]    shadow_q [NUM_REGS];
  logic [DW-1:0]    shadow_d [NUM_REGS];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;

  logic [IDX_W-1:0] wr_idx;
  logic             wr_hi;
  logic             copy_ok, step_ok, wr_ok, step_drop, wr_drop;
  logic [DW-1:0]    copy_val;
  logic             unused_wr_f;

  assign wr_idx      = rf_rn_in[IDX_W-1:0];
  assign wr_hi       = rf_rn_in[IDX_W];
  assign unused_wr_f = rf_rn_in[IDX_W+1];

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_L;
  endfunction

  function automatic logic [DW-1:0] sel_bytes(input logic [DW-1:0] val, input logic f, input logic h);
    if (f) return val;
    if (h) return {{BYTE_W{1'b0}}, val[DW-1:BYTE_W]};
    return {{BYTE_W{1'b0}}, val[BYTE_W-1:0]};
  endfunction

  // Indices past NUM_REGS match no loop iteration, so they read as zero.
  always_comb begin
    rf_data_out_a = '0;
    rf_data_out_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf_rn_out_a[IDX_W-1:0] == IDX_W'(i))
        rf_data_out_a = sel_bytes(regs_q[i], rf_rn_out_a[IDX_W+1], rf_rn_out_a[IDX_W]);
      if (rf_rn_out_b[IDX_W-1:0] == IDX_W'(i))
        rf_data_out_b = sel_bytes(regs_q[i], rf_rn_out_b[IDX_W+1], rf_rn_out_b[IDX_W]);
    end
  end

  // Same-register priority: copy beats step beats byte write; a self-copy counts as no op.
  always_comb begin
    copy_ok    = rf_copy_en && idx_ok(rf_copy_src) && idx_ok(rf_copy_dst) && (rf_copy_src != rf_copy_dst);
    step_ok    = rf_step_en && idx_ok(rf_step_idx);
    wr_ok      = rf_we && idx_ok(wr_idx);
    step_drop  = step_ok && copy_ok && (rf_step_idx == rf_copy_dst);
    wr_drop    = wr_ok && ((copy_ok && (wr_idx == rf_copy_dst)) || (step_ok && (wr_idx == rf_step_idx)));
    conflict_d = step_drop || wr_drop;
    copy_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf_copy_src == IDX_W'(i)) copy_val = regs_q[i];
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && !wr_drop && (wr_idx == IDX_W'(i))) begin
        if (wr_hi) regs_d[i][DW-1:BYTE_W] = rf_data_in;
        else       regs_d[i][BYTE_W-1:0]  = rf_data_in;
      end
      if (step_ok && !step_drop && (rf_step_idx == IDX_W'(i)))
        regs_d[i] = rf_step_dec ? regs_q[i] - DW'(1) : regs_q[i] + DW'(1);
      if (copy_ok && (rf_copy_dst == IDX_W'(i)))
        regs_d[i] = copy_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          shadow_d = regs_q;
          cnt_d    = '0;
          state_d  = DUMP;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat outputs come straight from the shadow, so they hold while dump_ready is low.
  always_comb begin
    dump_busy  = (state_q == DUMP);
    dump_valid = (state_q == DUMP);
    dump_idx   = (state_q == DUMP) ? cnt_q : '0;
    dump_data  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((state_q == DUMP) && (cnt_q == IDX_W'(i))) dump_data = shadow_q[i];
    end
  end

  assign rf_conflict = conflict_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      state_q    <= IDLE;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      shadow_q   <= shadow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, randomized ops against a
// behavioural model, and hand-written dump/reset sequences.
module tb_regfile_mp;
  localparam int N = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rf_rn_out_a, rf_rn_out_b;
  logic [15:0] rf_data_out_a, rf_data_out_b;
  logic        rf_we;
  logic [4:0]  rf_rn_in;
  logic [7:0]  rf_data_in;
  logic        rf_step_en;
  logic [2:0]  rf_step_idx;
  logic        rf_step_dec;
  logic        rf_copy_en;
  logic [2:0]  rf_copy_src, rf_copy_dst;
  logic        rf_conflict;
  logic        dump_req, dump_busy, dump_valid, dump_ready;
  logic [2:0]  dump_idx;
  logic [15:0] dump_data;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] model_regs [8];

  typedef struct {
    logic we; logic [4:0] rn_in; logic [7:0] din;
    logic sen; logic [2:0] sidx; logic sdec;
    logic cen; logic [2:0] csrc; logic [2:0] cdst;
    logic [4:0] rna; logic [15:0] exa; logic [4:0] rnb; logic [15:0] exb; logic conf;
  } vec_t;

  vec_t vecs [17];

  regfile_mp #(.NUM_REGS(N), .IDX_W(3), .BYTE_W(8)) dut (
    .clock(clock), .reset(reset),
    .rf_rn_out_a(rf_rn_out_a), .rf_rn_out_b(rf_rn_out_b),
    .rf_data_out_a(rf_data_out_a), .rf_data_out_b(rf_data_out_b),
    .rf_we(rf_we), .rf_rn_in(rf_rn_in), .rf_data_in(rf_data_in),
    .rf_step_en(rf_step_en), .rf_step_idx(rf_step_idx), .rf_step_dec(rf_step_dec),
    .rf_copy_en(rf_copy_en), .rf_copy_src(rf_copy_src), .rf_copy_dst(rf_copy_dst),
    .rf_conflict(rf_conflict),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input int we, input int rn, input int din, input int sen, input int sidx,
                              input int sdec, input int cen, input int csrc, input int cdst,
                              input int rna, input int exa, input int rnb, input int exb, input int conf);
    vec_t v;
    v.we = 1'(we); v.rn_in = 5'(rn); v.din = 8'(din);
    v.sen = 1'(sen); v.sidx = 3'(sidx); v.sdec = 1'(sdec);
    v.cen = 1'(cen); v.csrc = 3'(csrc); v.cdst = 3'(cdst);
    v.rna = 5'(rna); v.exa = 16'(exa); v.rnb = 5'(rnb); v.exb = 16'(exb); v.conf = 1'(conf);
    return v;
  endfunction

  // Reference read: code = {full, high, index}; out-of-range indices read as zero.
  function automatic logic [15:0] model_read(input logic [4:0] rn);
    int idx;
    idx = int'(rn[2:0]);
    if (idx >= N) return 16'h0000;
    if (rn[4]) return model_regs[idx];
    if (rn[3]) return {8'h00, model_regs[idx][15:8]};
    return {8'h00, model_regs[idx][7:0]};
  endfunction

  task automatic model_update(input vec_t v, output logic conf);
    int cur [8];
    int widx, sidx, src, dst;
    bit copy_act, step_act, wr_act;
    for (int i = 0; i < 8; i++) cur[i] = int'(model_regs[i]);
    widx = int'(v.rn_in[2:0]); sidx = int'(v.sidx); src = int'(v.csrc); dst = int'(v.cdst);
    copy_act = v.cen && src < N && dst < N && src != dst;
    step_act = v.sen && sidx < N;
    wr_act   = v.we && widx < N;
    conf = 1'b0;
    if (wr_act) begin
      if ((copy_act && widx == dst) || (step_act && widx == sidx)) conf = 1'b1;
      else if (v.rn_in[3]) model_regs[widx] = 16'((cur[widx] % 256) + int'(v.din) * 256);
      else model_regs[widx] = 16'((cur[widx] / 256) * 256 + int'(v.din));
    end
    if (step_act) begin
      if (copy_act && sidx == dst) conf = 1'b1;
      else model_regs[sidx] = 16'(v.sdec ? (cur[sidx] + 65535) % 65536 : (cur[sidx] + 1) % 65536);
    end
    if (copy_act) model_regs[dst] = 16'(cur[src]);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rf_we = v.we; rf_rn_in = v.rn_in; rf_data_in = v.din;
    rf_step_en = v.sen; rf_step_idx = v.sidx; rf_step_dec = v.sdec;
    rf_copy_en = v.cen; rf_copy_src = v.csrc; rf_copy_dst = v.cdst;
    rf_rn_out_a = v.rna; rf_rn_out_b = v.rnb;
  endtask

  task automatic clear_ops();
    rf_we = 1'b0; rf_rn_in = '0; rf_data_in = '0;
    rf_step_en = 1'b0; rf_step_idx = '0; rf_step_dec = 1'b0;
    rf_copy_en = 1'b0; rf_copy_src = '0; rf_copy_dst = '0;
  endtask

  task automatic write_byte(input logic [4:0] rn, input logic [7:0] d);
    rf_we = 1'b1; rf_rn_in = rn; rf_data_in = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic exp_conf;
    int beat;
    int cyc;

    //         we rn    din  sen sidx dec cen src dst  rna    exa       rnb    exb      conf
    vecs[0]  = mk(1, 'h0A, 'hAB, 0, 0, 0, 0, 0, 0, 'h12, 'hAB00, 'h0A, 'h00AB, 0);
    vecs[1]  = mk(1, 'h02, 'hCD, 0, 0, 0, 0, 0, 0, 'h12, 'hABCD, 'h0A, 'h00AB, 0);
    vecs[2]  = mk(1, 'h0C, 'hFF, 0, 0, 0, 0, 0, 0, 'h14, 'hFF00, 'h04, 'h0000, 0);
    vecs[3]  = mk(1, 'h04, 'hFF, 0, 0, 0, 0, 0, 0, 'h14, 'hFFFF, 'h0C, 'h00FF, 0);
    vecs[4]  = mk(1, 'h09, 'h77, 1, 4, 0, 0, 0, 0, 'h14, 'h0000, 'h11, 'h7700, 0);
    vecs[5]  = mk(1, 'h01, 'h88, 1, 4, 1, 0, 0, 0, 'h14, 'hFFFF, 'h11, 'h7788, 0);
    vecs[6]  = mk(1, 'h0A, 'h12, 0, 0, 0, 0, 0, 0, 'h12, 'h12CD, 'h11, 'h7788, 0);
    vecs[7]  = mk(1, 'h02, 'h34, 0, 0, 0, 0, 0, 0, 'h12, 'h1234, 'h14, 'hFFFF, 0);
    vecs[8]  = mk(1, 'h0C, 'h01, 0, 0, 0, 0, 0, 0, 'h14, 'h01FF, 'h12, 'h1234, 0);
    vecs[9]  = mk(1, 'h04, 'h00, 0, 0, 0, 0, 0, 0, 'h14, 'h0100, 'h12, 'h1234, 0);
    vecs[10] = mk(1, 'h04, 'h55, 1, 4, 0, 1, 2, 4, 'h14, 'h1234, 'h12, 'h1234, 1);
    vecs[11] = mk(0, 'h00, 'h00, 0, 0, 0, 0, 0, 0, 'h14, 'h1234, 'h04, 'h0034, 0);
    vecs[12] = mk(1, 'h0C, 'hEE, 1, 4, 0, 0, 0, 0, 'h14, 'h1235, 'h0C, 'h0012, 1);
    vecs[13] = mk(0, 'h00, 'h00, 1, 3, 0, 1, 3, 3, 'h13, 'h0001, 'h03, 'h0001, 0);
    vecs[14] = mk(1, 'h07, 'h99, 1, 6, 0, 1, 5, 0, 'h10, 'h0000, 'h17, 'h0000, 0);
    vecs[15] = mk(0, 'h00, 'h00, 1, 4, 0, 1, 4, 0, 'h10, 'h1235, 'h14, 'h1236, 0);
    vecs[16] = mk(1, 'h09, 'h66, 0, 0, 0, 1, 0, 1, 'h11, 'h1235, 'h09, 'h0012, 1);

    clear_ops();
    rf_rn_out_a = '0; rf_rn_out_b = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    for (int c = 0; c < 32; c++) begin
      rf_rn_out_a = 5'(c);
      rf_rn_out_b = 5'(31 - c);
      #1;
      checkOutput("reset_read_a", 32'(rf_data_out_a), 32'h0);
      checkOutput("reset_read_b", 32'(rf_data_out_b), 32'h0);
    end
    checkOutput("reset_conflict", 32'(rf_conflict), 32'h0);
    checkOutput("reset_busy", 32'(dump_busy), 32'h0);
    checkOutput("reset_valid", 32'(dump_valid), 32'h0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_a", i), 32'(rf_data_out_a), 32'(vecs[i].exa));
      checkOutput($sformatf("vec%0d_b", i), 32'(rf_data_out_b), 32'(vecs[i].exb));
      checkOutput($sformatf("vec%0d_conflict", i), 32'(rf_conflict), 32'(vecs[i].conf));
    end
    clear_ops();

    $display("[TB] randomized ops against model");
    do_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    for (int it = 0; it < 400; it++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.rn_in = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6))};
      v.din   = 8'($urandom);
      v.sen   = 1'($urandom_range(0, 1));
      v.sidx  = 3'($urandom_range(0, 6));
      v.sdec  = 1'($urandom_range(0, 1));
      v.cen   = 1'($urandom_range(0, 1));
      v.csrc  = 3'($urandom_range(0, 6));
      v.cdst  = 3'($urandom_range(0, 6));
      v.rna   = 5'($urandom);
      v.rnb   = 5'($urandom);
      applyStimulus(v);
      #1;
      checkOutput("rand_pre_a", 32'(rf_data_out_a), 32'(model_read(v.rna)));
      checkOutput("rand_pre_b", 32'(rf_data_out_b), 32'(model_read(v.rnb)));
      model_update(v, exp_conf);
      tick();
      checkOutput("rand_conflict", 32'(rf_conflict), 32'(exp_conf));
      checkOutput("rand_post_a", 32'(rf_data_out_a), 32'(model_read(v.rna)));
      checkOutput("rand_post_b", 32'(rf_data_out_b), 32'(model_read(v.rnb)));
    end
    clear_ops();

    $display("[TB] dump with stalls and concurrent writes");
    do_reset();
    for (int i = 0; i < N; i++) begin
      write_byte(5'h08 | 5'(i), 8'((i + 1) * 8'h11));
      write_byte(5'(i), 8'((i + 1) * 8'h11));
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    beat = 0;
    for (cyc = 0; cyc < 40 && beat < N; cyc++) begin
      checkOutput("dump_valid", 32'(dump_valid), 32'h1);
      checkOutput("dump_busy", 32'(dump_busy), 32'h1);
      checkOutput("dump_idx", 32'(dump_idx), 32'(beat));
      checkOutput("dump_data", 32'(dump_data), 32'((beat + 1) * 16'h1111));
      dump_ready = (cyc % 2 == 0);
      dump_req = (cyc == 3);
      rf_we = (cyc == 1 || cyc == 2);
      rf_rn_in = (cyc == 1) ? 5'h08 : 5'h00;
      rf_data_in = 8'hFF;
      tick();
      if (dump_ready) beat++;
    end
    dump_ready = 1'b0; dump_req = 1'b0; rf_we = 1'b0;
    checkOutput("dump_beats_done", 32'(beat), 32'(N));
    checkOutput("dump_end_busy", 32'(dump_busy), 32'h0);
    checkOutput("dump_end_valid", 32'(dump_valid), 32'h0);
    checkOutput("dump_end_idx", 32'(dump_idx), 32'h0);
    checkOutput("dump_end_data", 32'(dump_data), 32'h0);
    rf_rn_out_a = 5'h10;
    #1;
    checkOutput("reg0_after_dump", 32'(rf_data_out_a), 32'hFFFF);

    $display("[TB] reset during dump");
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    tick();
    tick();
    checkOutput("mid_dump_idx", 32'(dump_idx), 32'h2);
    checkOutput("mid_dump_data", 32'(dump_data), 32'h3333);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dump_ready = 1'b0;
    checkOutput("rst_dump_valid", 32'(dump_valid), 32'h0);
    checkOutput("rst_dump_busy", 32'(dump_busy), 32'h0);
    checkOutput("rst_dump_idx", 32'(dump_idx), 32'h0);
    checkOutput("rst_dump_data", 32'(dump_data), 32'h0);
    checkOutput("rst_conflict", 32'(rf_conflict), 32'h0);
    for (int i = 0; i < N; i++) begin
      rf_rn_out_a = 5'h10 | 5'(i);
      #1;
      checkOutput($sformatf("rst_reg%0d", i), 32'(rf_data_out_a), 32'h0);
    end
    write_byte(5'h00, 8'h42);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    checkOutput("restart_valid", 32'(dump_valid), 32'h1);
    checkOutput("restart_idx", 32'(dump_idx), 32'h0);
    checkOutput("restart_data", 32'(dump_data), 32'h0042);
    dump_ready = 1'b1;
    for (int i = 0; i < N; i++) tick();
    dump_ready = 1'b0;
    checkOutput("restart_end_busy", 32'(dump_busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port successor to the CPU's 16-bit register-pair file (BC, DE, HL, SP, PC in the default build). Provides:
- two independent read ports;
- one byte write port;
- one concurrent 16-bit increment/decrement port, for PC/SP stepping in parallel with a byte load;
- a generalised register-to-register copy (e.g. JP (HL));
- a handshaked snapshot dump port that replaces simulation-only register dumps with a synthesizable stream for the debug path.

## Interface
Parameters:
- NUM_REGS, 5, number of double-byte registers (index 0..NUM_REGS-1).
- IDX_W, 3, register index width; requires 2^IDX_W >= NUM_REGS.
- BYTE_W, 8, byte width; a full register is 2*BYTE_W bits.

Register code RN (IDX_W+2 bits) = {F, H, IDX}: F selects the full register, H selects the high byte, IDX is the register index.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- rf_rn_out_a, rf_rn_out_b  in  IDX_W+2  read-port register codes.
- rf_data_out_a, rf_data_out_b  out  2*BYTE_W  read data.
- rf_we  in  1  byte write enable.
- rf_rn_in  in  IDX_W+2  byte write target; F ignored.
- rf_data_in  in  BYTE_W  byte write data.
- rf_step_en  in  1  step a full register.
- rf_step_idx  in  IDX_W  step target.
- rf_step_dec  in  1  1 = decrement, 0 = increment.
- rf_copy_en  in  1  copy a full register.
- rf_copy_src, rf_copy_dst  in  IDX_W  copy source and destination.
- rf_conflict  out  1  registered pulse: a lower-priority update was dropped.
- dump_req  in  1  start a snapshot dump.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  IDX_W  register index of the current beat.
- dump_data  out  2*BYTE_W  snapshot value of the current beat.

## Operation
- Reads are combinational from stored state.
  - F=1: output is the full register.
  - F=0: output is {0, selected byte}.
  - IDX >= NUM_REGS: output is 0.
  - There is no write bypass; reads return the pre-edge value.
- All three update ops may target different registers in the same cycle; all of them take effect.
- Same-register collision priority is copy (to dst) > step > byte write.
  - Each dropped op pulses rf_conflict for one cycle, on the edge after the collision.
  - A byte write is dropped entirely, even when it targets the other byte.
- Copy uses the pre-edge value of src. src == dst is a no-op and is not a conflict.
- Step is modulo 2^(2*BYTE_W): 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF.
- Any op with an out-of-range index is ignored, with no conflict pulse.
- Dump FSM has two states, IDLE and DUMP.
  - IDLE with dump_req=1: capture all registers (pre-edge values, before that cycle's updates) into a shadow array; go to DUMP with beat counter = 0.
  - In DUMP: dump_valid=1, dump_idx = counter, dump_data = shadow[counter].
    - Beat transfers when dump_valid & dump_ready.
    - Counter increments on each transfer.
    - After the beat for NUM_REGS-1 transfers, return to IDLE.
  - dump_req is ignored while in DUMP.
  - Register updates continue during a dump and never alter the shadow.
  - While a beat is stalled, dump_valid, dump_idx and dump_data hold stable.
- Reset on any cycle, including mid-dump:
  - all registers = 0;
  - FSM = IDLE;
  - counter = 0;
  - dump_busy = dump_valid = rf_conflict = 0;
  - dump_idx = 0, dump_data = 0.

## Timing
- Write, step and copy: single-cycle latency; visible on read ports the cycle after the edge.
- rf_conflict is registered; it is asserted in the cycle after the colliding cycle.
- dump_req sampled at edge t → dump_busy = dump_valid = 1 from t+1.
- With dump_ready held high, a dump takes exactly NUM_REGS beats. dump_busy and dump_valid fall after the edge that transfers the last beat.
- A new dump_req is accepted no earlier than the cycle in which dump_busy = 0.
- dump_busy == dump_valid at all times; the split is kept for future multi-cycle capture.

## Test plan
- Reset, then read all codes on both ports → all 0, rf_conflict = 0, dump_busy = 0.
- Write 0xAB to H of reg 2 and 0xCD to L of reg 2 (two cycles). Then port A = {F,2} → 0xABCD; port B = {H,2} → 0x00AB.
- Step reg 4 from 0xFFFF with inc → 0x0000. Step it again with dec → 0xFFFF. In the same cycles, byte-write reg 1 → both updates land.
- Reg 2 = 0x1234, reg 4 = 0x0100. Same cycle: copy 2→4, inc reg 4, byte-write reg 4 L = 0x55. Required: reg 4 = 0x1234, rf_conflict high for one cycle.
- Regs = 0x1111..0x5555. Pulse dump_req. Toggle dump_ready 1/0 and write reg 0 = 0xFFFF mid-dump. Required: beats idx 0..4 with data 0x1111..0x5555, data stable while stalled, busy drops after idx 4.
- Assert reset during beat 2 → next cycle dump_valid = 0 and all registers = 0. A fresh dump_req then restarts at idx 0.
